// File: rtl/nes_clock_enables.sv
// nes_clock_enables
// Turns the PLL master clock and its lock flag into a core reset plus the
// single-cycle PPU/CPU clock enables and the CPU M2 bus phase.
module nes_clock_enables #(
  parameter int LOCK_DELAY = 1024,
  parameter int CPU_DIV    = 12,
  parameter int PPU_DIV    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       pause,
  output logic       sys_reset,
  output logic       ppu_ce,
  output logic       cpu_ce,
  output logic       m2,
  output logic [7:0] lock_loss_count
);

  localparam int HOLD_W  = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam int PHASE_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LOCK_DELAY - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CPU_DIV - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_lock_s1;
  logic               r_lock_s2;
  logic               r_pause;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_cnt_next;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_next;
  logic [7:0]         r_loss_cnt;
  logic               w_lock_lost;
  logic               w_run;
  logic [CPU_DIV-1:0] w_ppu_slot;
  logic [CPU_DIV-1:0] w_m2_slot;

  // Per-phase decode tables: which phases carry a PPU dot and which have M2 high.
  for (genvar gi = 0; gi < CPU_DIV; gi++) begin : g_slot
    assign w_ppu_slot[gi] = ((gi % PPU_DIV) == 0);
    assign w_m2_slot[gi]  = (gi >= (CPU_DIV / 4));
  end

  // Two-flop synchronizer for the PLL lock flag, which is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= locked;
      r_lock_s2 <= r_lock_s1;
    end
  end

  // Register pause so the enables never depend combinationally on an input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pause <= 1'b0;
    end else begin
      r_pause <= pause;
    end
  end

  // Lock-tracking state machine: next state and hold-counter update.
  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    w_lock_lost     = 1'b0;
    case (r_state)
      S_WAIT_LOCK: begin
        w_hold_cnt_next = '0;
        if (r_lock_s2) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
        // A lock drop wins over reaching the end of the hold window.
        if (!r_lock_s2) begin
          w_state_next = S_WAIT_LOCK;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!r_lock_s2) begin
          w_state_next = S_WAIT_LOCK;
          w_lock_lost  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_WAIT_LOCK;
      end
    endcase
  end

  // State and hold-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_WAIT_LOCK;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  // Phase counter: parked at 0 outside RUN, frozen while paused, else wraps.
  always_comb begin
    w_phase_next = '0;
    if (r_state == S_RUN) begin
      if (r_pause) begin
        w_phase_next = r_phase;
      end else if (r_phase == PHASE_LAST) begin
        w_phase_next = '0;
      end else begin
        w_phase_next = r_phase + PHASE_W'(1);
      end
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Saturating count of lock losses seen while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loss_cnt <= '0;
    end else if (w_lock_lost && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  // Outputs decoded from registers only.
  assign w_run           = (r_state == S_RUN);
  assign sys_reset       = ~w_run;
  assign cpu_ce          = w_run & ~r_pause & (r_phase == '0);
  assign ppu_ce          = w_run & ~r_pause & w_ppu_slot[r_phase];
  assign m2              = w_run & w_m2_slot[r_phase];
  assign lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_nes_clock_enables.sv
// tb_nes_clock_enables
// Directed bench for nes_clock_enables with LOCK_DELAY=16, CPU_DIV=12, PPU_DIV=4.
module tb_nes_clock_enables;

  logic       clk;
  logic       reset;
  logic       locked;
  logic       pause;
  logic       sys_reset;
  logic       ppu_ce;
  logic       cpu_ce;
  logic       m2;
  logic [7:0] lock_loss_count;

  int n_checks = 0;
  int n_bad    = 0;

  // Hand-written per-phase expectations, bit p = phase p.
  logic [11:0] cpu_pat = 12'b0000_0000_0001;
  logic [11:0] ppu_pat = 12'b0001_0001_0001;
  logic [11:0] m2_pat  = 12'b1111_1111_1000;

  nes_clock_enables #(
    .LOCK_DELAY(16),
    .CPU_DIV   (12),
    .PPU_DIV   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .locked         (locked),
    .pause          (pause),
    .sys_reset      (sys_reset),
    .ppu_ce         (ppu_ce),
    .cpu_ce         (cpu_ce),
    .m2             (m2),
    .lock_loss_count(lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after locked has been raised; expects release after edge 3+16.
  task automatic acquire(input string tag);
    repeat (18) tick();
    check_eq({tag, "_still_reset"}, sys_reset, 1);
    tick();
    check_eq({tag, "_released"}, sys_reset, 0);
    check_eq({tag, "_cpu_ce_first"}, cpu_ce, 1);
    check_eq({tag, "_ppu_ce_first"}, ppu_ce, 1);
    check_eq({tag, "_m2_first"}, m2, 0);
    $display("acquire %s: sys_reset released at t=%0t", tag, $time);
  endtask

  initial begin
    int cpu_cnt;
    int ppu_cnt;
    int exp_loss;
    reset  = 1'b1;
    locked = 1'b0;
    pause  = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check_eq("rst_sys_reset", sys_reset, 1);
    check_eq("rst_cpu_ce", cpu_ce, 0);
    check_eq("rst_ppu_ce", ppu_ce, 0);
    check_eq("rst_m2", m2, 0);
    check_eq("rst_loss", lock_loss_count, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check_eq("nolock_sys_reset", sys_reset, 1);
    $display("reset: outputs idle, no lock");

    // Lock drop during HOLD with the hold counter at 10.
    locked = 1'b1;
    repeat (13) tick();
    locked = 1'b0;
    repeat (5) tick();
    check_eq("hold_drop_sys_reset", sys_reset, 1);
    check_eq("hold_drop_loss", lock_loss_count, 0);
    $display("hold drop: back to wait, loss=%0d", lock_loss_count);
    locked = 1'b1;
    acquire("hold_relock");

    // Two full CPU periods of enables and M2.
    for (int p = 1; p < 24; p++) begin
      tick();
      check_eq($sformatf("seq_cpu_p%0d", p), cpu_ce, cpu_pat[p % 12]);
      check_eq($sformatf("seq_ppu_p%0d", p), ppu_ce, ppu_pat[p % 12]);
      check_eq($sformatf("seq_m2_p%0d", p), m2, m2_pat[p % 12]);
    end
    $display("sequence: 24 cycles of enables checked");

    // Three-cycle lock drop while running.
    locked = 1'b0;
    tick();
    tick();
    check_eq("run_drop_edge2_sys_reset", sys_reset, 0);
    tick();
    check_eq("run_drop_sys_reset", sys_reset, 1);
    check_eq("run_drop_cpu_ce", cpu_ce, 0);
    check_eq("run_drop_ppu_ce", ppu_ce, 0);
    check_eq("run_drop_m2", m2, 0);
    check_eq("run_drop_loss", lock_loss_count, 1);
    $display("run drop: loss=%0d", lock_loss_count);
    locked = 1'b1;
    acquire("run_relock");

    // Pause for 7 cycles starting at phase 5, counted over 1200 cycles.
    cpu_cnt = 0;
    ppu_cnt = 0;
    for (int i = 0; i < 1200; i++) begin
      if (cpu_ce) cpu_cnt++;
      if (ppu_ce) ppu_cnt++;
      if (i >= 6 && i <= 12) begin
        check_eq($sformatf("pause_cpu_i%0d", i), cpu_ce, 0);
        check_eq($sformatf("pause_ppu_i%0d", i), ppu_ce, 0);
      end
      if (i == 9) check_eq("pause_m2_held", m2, 1);
      if (i == 14) check_eq("resume_ppu_phase7", ppu_ce, 0);
      if (i == 15) begin
        check_eq("resume_ppu_phase8", ppu_ce, 1);
        check_eq("resume_cpu_phase8", cpu_ce, 0);
      end
      if (i == 19) begin
        check_eq("resume_cpu_phase0", cpu_ce, 1);
        check_eq("resume_ppu_phase0", ppu_ce, 1);
      end
      if (i == 5) pause = 1'b1;
      if (i == 12) pause = 1'b0;
      tick();
    end
    check_eq("pause_cpu_total", cpu_cnt, 100);
    check_eq("pause_ppu_total", ppu_cnt, 299);
    $display("pause: cpu_ce=%0d ppu_ce=%0d over 1200 cycles", cpu_cnt, ppu_cnt);

    // Drive lock-loss events up to 300 in total; the counter saturates.
    locked = 1'b1;
    repeat (19) tick();
    for (int e = 2; e <= 300; e++) begin
      locked = 1'b0;
      repeat (3) tick();
      if (e == 2 || e == 254 || e == 255 || e == 256 || e == 300) begin
        exp_loss = (e > 255) ? 255 : e;
        check_eq($sformatf("sat_loss_e%0d", e), lock_loss_count, exp_loss);
      end
      locked = 1'b1;
      repeat (19) tick();
    end
    check_eq("sat_running", sys_reset, 0);
    $display("saturation: loss=%0d after 300 events", lock_loss_count);

    // Asynchronous reset mid-RUN at phase 4, away from any clock edge.
    repeat (4) tick();
    check_eq("pre_areset_ppu", ppu_ce, 1);
    check_eq("pre_areset_m2", m2, 1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("areset_sys_reset", sys_reset, 1);
    check_eq("areset_ppu", ppu_ce, 0);
    check_eq("areset_cpu", cpu_ce, 0);
    check_eq("areset_m2", m2, 0);
    check_eq("areset_loss", lock_loss_count, 0);
    tick();
    tick();
    reset = 1'b0;
    acquire("after_areset");
    check_eq("after_areset_loss", lock_loss_count, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/nes_clock_enables.md
# nes_clock_enables

Clock-enable and system-reset generator sitting directly downstream of the PLL. It consumes the PLL's 21.4737 MHz master clock and asynchronous `locked` flag, holds the NES core in reset until lock has been stable for a programmable time, then emits the single-cycle PPU (master/4) and CPU (master/12) clock enables plus the M2 bus phase. All NES logic runs on the master clock, gated by these enables.

## Interface
Parameters:
- `LOCK_DELAY`, 1024: master cycles lock must be stable before reset release (≥2).
- `CPU_DIV`, 12: master cycles per CPU cycle.
- `PPU_DIV`, 4: master cycles per PPU dot; must divide `CPU_DIV`.

Ports:
- `clk`  in  1  master clock (PLL `clkout0`, 21.4737 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `locked`  in  1  PLL lock flag, asynchronous to `clk`.
- `pause`  in  1  freeze enables (debug/OSD), synchronous.
- `sys_reset`  out  1  core reset, high while not running.
- `ppu_ce`  out  1  one-cycle PPU enable.
- `cpu_ce`  out  1  one-cycle CPU enable.
- `m2`  out  1  CPU M2 phase.
- `lock_loss_count`  out  8  saturating count of lock losses since `reset`.

## Operation
- `locked` passes through a 2-flop synchronizer (`lock_s1`, `lock_s2`), both reset to 0.
- States: WAIT_LOCK, HOLD, RUN. Reset → WAIT_LOCK.
  - WAIT_LOCK: `lock_s2`=1 → HOLD, hold counter cleared to 0.
  - HOLD: counter increments every cycle; `lock_s2`=0 → WAIT_LOCK; counter == `LOCK_DELAY`-1 → RUN.
  - RUN: `lock_s2`=0 → WAIT_LOCK and `lock_loss_count` increments (saturates at 255).
  - A drop of `lock_s2` takes priority over reaching `LOCK_DELAY`-1 in the same cycle.
- Hold counter width: $clog2(`LOCK_DELAY`).
- Phase counter `phase`, range 0..`CPU_DIV`-1:
  - Forced to 0 outside RUN.
  - In RUN, increments and wraps `CPU_DIV`-1 → 0, except when `pause_r`=1, where it holds.
- `pause_r`: `pause` registered, reset 0.
- Outputs are registered or decoded from registers only; there is no input-to-output combinational path.
  - `sys_reset` = (state != RUN).
  - `cpu_ce` = RUN & ~`pause_r` & (`phase`==0).
  - `ppu_ce` = RUN & ~`pause_r` & (`phase` mod `PPU_DIV`==0).
  - `m2` = RUN & (`phase` ≥ `CPU_DIV`/4). `m2` is not gated by pause, so it holds its level while paused.
- Reset values: `sys_reset`=1; `cpu_ce`, `ppu_ce`, `m2`=0; `lock_loss_count`=0; state WAIT_LOCK; `phase`=0.

## Timing
- Edge n = nth rising `clk` edge sampling `locked`=1, with n=1 the first.
- Lock acquisition:
  - `lock_s2`=1 after edge 2.
  - State = HOLD after edge 3.
  - RUN and `sys_reset`=0 after edge 3+`LOCK_DELAY`.
- The first cycle with `sys_reset`=0 has `phase`=0, so `cpu_ce`=`ppu_ce`=1. Thereafter:
  - `ppu_ce` every `PPU_DIV` cycles.
  - `cpu_ce` every `CPU_DIV` cycles.
  - Every `cpu_ce` coincides with a `ppu_ce`.
- Lock loss: `sys_reset` rises after the 3rd edge sampling `locked`=0. Enables and `m2` drop in that same cycle.
- Pause:
  - Asserting `pause` suppresses enables from the next cycle.
  - On deassertion, the sequence resumes at the held phase one cycle later. No enable is lost or duplicated.
- A `locked` glitch shorter than one `clk` period may be missed. A glitch of 2 or more cycles is always seen.
- `reset` asserted mid-RUN clears all state immediately (asynchronously). After release, the full acquisition sequence is required again.

## Test plan
- `LOCK_DELAY`=16, `locked` 0→1 at edge 10 → `sys_reset` falls after edge 29; `cpu_ce`=`ppu_ce`=1 in that cycle; `ppu_ce` at +4 and +8; `cpu_ce` and `ppu_ce` together at +12; `m2` low for `phase` 0–2, high for 3–11.
- `locked` drops for 5 cycles during HOLD (counter at 10) → returns to WAIT_LOCK, `lock_loss_count` stays 0, and the full 16-cycle hold restarts after relock.
- `locked` drops for 3 cycles in RUN → `sys_reset`=1 three edges later, enables 0, `lock_loss_count`=1; after relock, the phase restarts at 0.
- `pause` held 7 cycles starting at `phase`=5 → no enables during the pause; the next `ppu_ce` comes at `phase`=8 and the next `cpu_ce` at `phase`=0, with the total count over 1200 cycles equal to unpaused count minus paused cycles/period.
- 300 lock-loss events → `lock_loss_count` saturates at 255.
- Async `reset` pulse mid-RUN (not clock-aligned) → all outputs reach reset values immediately and recovery repeats the edge-3+`LOCK_DELAY` timing.
